rvb_xperm_issue: RTL and testbench

Issue/sequencing stage directly upstream of the `rvb_xperm` crossbar-permutation unit in the Bitmanip execute path. It does four things:
- accepts a decoded-register-read instruction from the dispatch stage over a valid/ready handshake;
- decodes `xperm.n`/`xperm.b` (Zbkx);
- drives `rvb_xperm` with stable operands and a two-cycle `xperm_valid` window, then captures its result;
- presents the result to writeback over a second valid/ready handshake.

Non-xperm instructions are flagged illegal without touching `rvb_xperm`.

---
 rtl/rvb_xperm_pkg.sv | 17 +
 rtl/rvb_xperm_decode.sv | 29 ++
 rtl/rvb_xperm_issue.sv | 164 ++++++++++++++++
 tb/tb_rvb_xperm_issue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvb_xperm_pkg.sv
// Shared bitmanip definitions for the xperm issue stage.
// Holds the Zbkx encoding constants and the issue FSM state type.
package rvb_xperm_pkg;

  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] F7_XPERM   = 7'b0010100;
  localparam logic [2:0] F3_XPERM_N = 3'b010;
  localparam logic [2:0] F3_XPERM_B = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rvb_xperm_decode.sv
// Combinational decoder for xperm.n / xperm.b.
// Ports:
//   instr   - raw 32-bit instruction word
//   is_n    - instruction is xperm.n
//   is_b    - instruction is xperm.b
//   illegal - instruction is neither of the above
//   rd      - destination register field
module rvb_xperm_decode
  import rvb_xperm_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_n,
  output logic        is_b,
  output logic        illegal,
  output logic [4:0]  rd
);

  logic base_match;
  // Register source fields are irrelevant to decode; the operand values arrive separately.
  logic unused_src_fields;

  assign unused_src_fields = ^instr[24:15];
  assign base_match = (instr[6:0] == OP_REG) && (instr[31:25] == F7_XPERM);
  assign is_n       = base_match && (instr[14:12] == F3_XPERM_N);
  assign is_b       = base_match && (instr[14:12] == F3_XPERM_B);
  assign illegal    = !(is_n || is_b);
  assign rd         = instr[11:7];

endmodule

// File: rtl/rvb_xperm_issue.sv
// Issue/sequencing stage in front of the rvb_xperm crossbar unit.
// Accepts an instruction from dispatch, holds operands stable for a two-cycle
// xperm_valid window, captures the crossbar result and offers it to writeback.
// Ports:
//   clk, rst              - clock, async active-high reset
//   flush                 - synchronous kill of any in-flight op
//   in_valid/in_ready     - dispatch handshake; in_instr, in_rs1, in_rs2 payload
//   xperm_valid, op_xperm_n, op_xperm_b, xperm_rs1, xperm_rs2 - drive rvb_xperm
//   xperm_res             - result from rvb_xperm
//   wb_valid/wb_ready     - writeback handshake; wb_rd, wb_we, wb_data, wb_illegal payload
module rvb_xperm_issue
  import rvb_xperm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            xperm_valid,
  output logic            op_xperm_n,
  output logic            op_xperm_b,
  output logic [XLEN-1:0] xperm_rs1,
  output logic [XLEN-1:0] xperm_rs2,
  input  logic [XLEN-1:0] xperm_res,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal
);

  state_t          state_q, state_d;
  logic            xperm_valid_q, xperm_valid_d;
  logic            op_n_q, op_n_d;
  logic            op_b_q, op_b_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_illegal_q, wb_illegal_d;

  logic            dec_n, dec_b, dec_illegal;
  logic [4:0]      dec_rd;
  logic            accept;

  rvb_xperm_decode u_decode (
    .instr   (in_instr),
    .is_n    (dec_n),
    .is_b    (dec_b),
    .illegal (dec_illegal),
    .rd      (dec_rd)
  );

  // Single-entry stage: a new op may only enter when empty or when the
  // result in DONE is leaving this very cycle. Flush blocks any entry.
  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && wb_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    op_n_d       = op_n_q;
    op_b_d       = op_b_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    wb_rd_d      = wb_rd_q;
    wb_we_d      = wb_we_q;
    wb_data_d    = wb_data_q;
    wb_illegal_d = wb_illegal_q;

    case (state_q)
      EXEC1: state_d = EXEC2;
      EXEC2: begin
        state_d = DONE;
        // A flush at the capture edge discards the result entirely.
        if (!flush) begin
          wb_rd_d      = rd_q;
          wb_we_d      = (rd_q != 5'd0);
          wb_data_d    = xperm_res;
          wb_illegal_d = 1'b0;
        end
      end
      DONE: if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accept can only fire from IDLE or a draining DONE, so it overrides the
    // transitions above for those states.
    if (accept) begin
      op_n_d = dec_n;
      op_b_d = dec_b;
      rs1_d  = in_rs1;
      rs2_d  = in_rs2;
      rd_d   = dec_rd;
      if (dec_illegal) begin
        // Illegal ops skip the crossbar and report straight away.
        state_d      = DONE;
        wb_rd_d      = dec_rd;
        wb_we_d      = 1'b0;
        wb_data_d    = '0;
        wb_illegal_d = 1'b1;
      end else begin
        state_d = EXEC1;
      end
    end

    if (flush) state_d = IDLE;

    // Outputs are registered so they line up exactly with the state they belong to.
    xperm_valid_d = (state_d == EXEC1) || (state_d == EXEC2);
    wb_valid_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      xperm_valid_q <= 1'b0;
      op_n_q        <= 1'b0;
      op_b_q        <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_we_q       <= 1'b0;
      wb_data_q     <= '0;
      wb_illegal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      xperm_valid_q <= xperm_valid_d;
      op_n_q        <= op_n_d;
      op_b_q        <= op_b_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_we_q       <= wb_we_d;
      wb_data_q     <= wb_data_d;
      wb_illegal_q  <= wb_illegal_d;
    end
  end

  assign xperm_valid = xperm_valid_q;
  assign op_xperm_n  = op_n_q;
  assign op_xperm_b  = op_b_q;
  assign xperm_rs1   = rs1_q;
  assign xperm_rs2   = rs2_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_we       = wb_we_q;
  assign wb_data     = wb_data_q;
  assign wb_illegal  = wb_illegal_q;

endmodule

// File: tb/tb_rvb_xperm_issue.sv
// Directed testbench for rvb_xperm_issue. A behavioural crossbar stands in
// for rvb_xperm; all expected values are hand-computed constants.
module tb_rvb_xperm_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        xperm_valid;
  logic        op_xperm_n;
  logic        op_xperm_b;
  logic [31:0] xperm_rs1;
  logic [31:0] xperm_rs2;
  logic [31:0] xperm_res;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        wb_illegal;

  int compareCount;
  int failCount;

  rvb_xperm_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .xperm_valid (xperm_valid),
    .op_xperm_n  (op_xperm_n),
    .op_xperm_b  (op_xperm_b),
    .xperm_rs1   (xperm_rs1),
    .xperm_rs2   (xperm_rs2),
    .xperm_res   (xperm_res),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .wb_data     (wb_data),
    .wb_illegal  (wb_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the rvb_xperm crossbar fed by the stage's registered operands.
  function automatic logic [31:0] xpermModel(input logic [31:0] a, input logic [31:0] b,
                                              input logic isN, input logic isB);
    logic [31:0] r;
    r = '0;
    if (isN) begin
      for (int i = 0; i < 8; i++) begin
        if (b[i*4 +: 4] < 4'd8) r[i*4 +: 4] = a[b[i*4 +: 3]*4 +: 4];
      end
    end else if (isB) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i*8 +: 8] < 8'd4) r[i*8 +: 8] = a[b[i*8 +: 2]*8 +: 8];
      end
    end
    return r;
  endfunction

  always_comb xperm_res = xpermModel(xperm_rs1, xperm_rs2, op_xperm_n, op_xperm_b);

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic ready, input logic fl);
    in_valid = valid;
    in_instr = instr;
    in_rs1   = rs1;
    in_rs2   = rs2;
    wb_ready = ready;
    flush    = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rst_xperm_valid", {31'b0, xperm_valid}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_xperm_rs1", xperm_rs1, 32'h0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // xperm.n x5,x6,x7
    applyStimulus(1'b1, 32'h287322B3, 32'h76543210, 32'h01234567, 1'b1, 1'b0);
    checkOutput("n_in_ready", {31'b0, in_ready}, 32'd1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("n_e1_xvalid", {31'b0, xperm_valid}, 32'd1);
    checkOutput("n_e1_op", {30'b0, op_xperm_n, op_xperm_b}, 32'd2);
    checkOutput("n_e1_rs1", xperm_rs1, 32'h76543210);
    checkOutput("n_e1_rs2", xperm_rs2, 32'h01234567);
    checkOutput("n_e1_wbvalid", {31'b0, wb_valid}, 32'd0);
    checkOutput("n_e1_in_ready", {31'b0, in_ready}, 32'd0);
    stepCycle();
    checkOutput("n_e2_xvalid", {31'b0, xperm_valid}, 32'd1);
    checkOutput("n_e2_rs2", xperm_rs2, 32'h01234567);
    stepCycle();
    checkOutput("n_done_xvalid", {31'b0, xperm_valid}, 32'd0);
    checkOutput("n_done_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkOutput("n_done_data", wb_data, 32'h01234567);
    checkOutput("n_done_rd", {27'b0, wb_rd}, 32'd5);
    checkOutput("n_done_we", {31'b0, wb_we}, 32'd1);
    checkOutput("n_done_illegal", {31'b0, wb_illegal}, 32'd0);
    stepCycle();
    checkOutput("n_idle_wbvalid", {31'b0, wb_valid}, 32'd0);

    // xperm.b with backpressure, then back-to-back accept
    applyStimulus(1'b1, 32'h287342B3, 32'h44332211, 32'h00010203, 1'b0, 1'b0);
    stepCycle();
    checkOutput("b_e1_op", {30'b0, op_xperm_n, op_xperm_b}, 32'd1);
    applyStimulus(1'b1, 32'h287342B3, 32'h44332211, 32'h04050607, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("b_done_data", wb_data, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_wbvalid", {31'b0, wb_valid}, 32'd1);
      checkOutput("bp_data", wb_data, 32'h11223344);
      checkOutput("bp_rd", {27'b0, wb_rd}, 32'd5);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      stepCycle();
    end
    applyStimulus(1'b1, 32'h287342B3, 32'h44332211, 32'h04050607, 1'b1, 1'b0);
    checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("b2_e1_xvalid", {31'b0, xperm_valid}, 32'd1);
    checkOutput("b2_e1_wbvalid", {31'b0, wb_valid}, 32'd0);
    checkOutput("b2_e1_rs2", xperm_rs2, 32'h04050607);
    stepCycle();
    stepCycle();
    checkOutput("b2_done_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkOutput("b2_done_data", wb_data, 32'h00000000);
    stepCycle();

    // Illegal instruction
    applyStimulus(1'b1, 32'h00000013, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("ill_xvalid", {31'b0, xperm_valid}, 32'd0);
    checkOutput("ill_op", {30'b0, op_xperm_n, op_xperm_b}, 32'd0);
    checkOutput("ill_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkOutput("ill_flag", {31'b0, wb_illegal}, 32'd1);
    checkOutput("ill_data", wb_data, 32'h0);
    checkOutput("ill_we", {31'b0, wb_we}, 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("ill_drained", {31'b0, wb_valid}, 32'd0);

    // Flush blocks accept in IDLE, then kills an op in EXEC1
    applyStimulus(1'b1, 32'h287322B3, 32'h76543210, 32'h01234567, 1'b1, 1'b1);
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b1, 32'h287322B3, 32'h76543210, 32'h01234567, 1'b1, 1'b0);
    stepCycle();
    checkOutput("fl_e1_xvalid", {31'b0, xperm_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("fl_xvalid", {31'b0, xperm_valid}, 32'd0);
    checkOutput("fl_wbvalid", {31'b0, wb_valid}, 32'd0);
    checkOutput("fl_in_ready", {31'b0, in_ready}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("fl_no_wb", {31'b0, wb_valid}, 32'd0);

    // Async reset in EXEC2
    applyStimulus(1'b1, 32'h287322B3, 32'h76543210, 32'h01234567, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("ar_e2_xvalid", {31'b0, xperm_valid}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("ar_xvalid", {31'b0, xperm_valid}, 32'd0);
    checkOutput("ar_op", {30'b0, op_xperm_n, op_xperm_b}, 32'd0);
    checkOutput("ar_rs1", xperm_rs1, 32'h0);
    checkOutput("ar_rs2", xperm_rs2, 32'h0);
    checkOutput("ar_wbdata", wb_data, 32'h0);
    #1 rst = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("ar_no_wb", {31'b0, wb_valid}, 32'd0);

    // xperm.n with rd = x0
    applyStimulus(1'b1, 32'h28732033, 32'h76543210, 32'h01234567, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("rd0_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkOutput("rd0_we", {31'b0, wb_we}, 32'd0);
    checkOutput("rd0_rd", {27'b0, wb_rd}, 32'd0);
    checkOutput("rd0_data", wb_data, 32'h01234567);
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
